// File: rtl/square_drawer.sv
// Square rasteriser for a VGA pixel adapter: one SIZE x SIZE square per start, one pixel per cycle.
// Optional macro SQUARE_BORDER_EN draws only the outline; timing stays identical.
module square_drawer #(
    parameter int SIZE  = 4,
    parameter int X_MAX = 159,
    parameter int Y_MAX = 119
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       start,
    input  logic [7:0] starting_x,
    input  logic [6:0] starting_y,
    input  logic [2:0] colour_in,
    output logic [7:0] x,
    output logic [6:0] y,
    output logic [2:0] colour,
    output logic       writeEn,
    output logic       busy,
    output logic       done
);

    localparam int NPIX = SIZE * SIZE;
    localparam int CW   = $clog2(NPIX);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        DRAW = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t        state, state_nxt;
    logic [CW-1:0] cnt;
    logic [7:0]    lat_x;
    logic [6:0]    lat_y;
    logic [2:0]    lat_colour;

    logic [CW-1:0] col, row;
    logic [8:0]    x_full;
    logic [7:0]    y_full;
    logic          in_bounds;
    logic          on_edge;
    logic          last_pix;

    assign col      = cnt % CW'(SIZE);
    assign row      = cnt / CW'(SIZE);
    assign last_pix = (cnt == CW'(NPIX - 1));

    // Keep the carry so pixels past the screen edge are clipped, not wrapped.
    assign x_full    = {1'b0, lat_x} + {{(9 - CW){1'b0}}, col};
    assign y_full    = {1'b0, lat_y} + {{(8 - CW){1'b0}}, row};
    assign in_bounds = (x_full <= 9'(X_MAX)) && (y_full <= 8'(Y_MAX));

`ifdef SQUARE_BORDER_EN
    assign on_edge = (row == '0) || (row == CW'(SIZE - 1)) ||
                     (col == '0) || (col == CW'(SIZE - 1));
`else
    assign on_edge = 1'b1;
`endif

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= IDLE;
            cnt        <= '0;
            lat_x      <= '0;
            lat_y      <= '0;
            lat_colour <= '0;
        end else begin
            state <= state_nxt;
            case (state)
                IDLE: begin
                    if (start) begin
                        lat_x      <= starting_x;
                        lat_y      <= starting_y;
                        lat_colour <= colour_in;
                        cnt        <= '0;
                    end
                end
                DRAW:    cnt <= cnt + 1'b1;
                default: ;
            endcase
        end
    end

    always_comb begin
        state_nxt = state;
        x         = '0;
        y         = '0;
        colour    = '0;
        writeEn   = 1'b0;
        busy      = 1'b0;
        done      = 1'b0;
        case (state)
            IDLE: begin
                if (start) state_nxt = DRAW;
            end
            DRAW: begin
                busy    = 1'b1;
                x       = x_full[7:0];
                y       = y_full[6:0];
                colour  = lat_colour;
                writeEn = in_bounds && on_edge;
                if (last_pix) state_nxt = DONE;
            end
            DONE: begin
                busy      = 1'b1;
                done      = 1'b1;
                state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

endmodule

// File: tb/tb_square_drawer.sv
// Randomised self-checking bench for square_drawer; the expected pixel stream is
// derived from plain raster arithmetic (row-major walk, screen clipping, optional outline).
module tb_square_drawer;

    localparam int SIZE  = 4;
    localparam int X_MAX = 159;
    localparam int Y_MAX = 119;
`ifdef SQUARE_BORDER_EN
    localparam bit BORDER = 1'b1;
`else
    localparam bit BORDER = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       reset;
    logic       start;
    logic [7:0] starting_x;
    logic [6:0] starting_y;
    logic [2:0] colour_in;
    logic [7:0] x;
    logic [6:0] y;
    logic [2:0] colour;
    logic       writeEn;
    logic       busy;
    logic       done;

    int n_tests = 0;
    int n_fail  = 0;

    square_drawer #(.SIZE(SIZE), .X_MAX(X_MAX), .Y_MAX(Y_MAX)) dut (
        .clk        (clk),
        .reset      (reset),
        .start      (start),
        .starting_x (starting_x),
        .starting_y (starting_y),
        .colour_in  (colour_in),
        .x          (x),
        .y          (y),
        .colour     (colour),
        .writeEn    (writeEn),
        .busy       (busy),
        .done       (done)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input int got, input int exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic chk_quiet(input string tag);
        chk({tag, "_we"},     int'(writeEn), 0);
        chk({tag, "_x"},      int'(x),       0);
        chk({tag, "_y"},      int'(y),       0);
        chk({tag, "_colour"}, int'(colour),  0);
    endtask

    function automatic int span(input int s, input int lim);
        int w;
        w = lim + 1 - s;
        if (w < 0) w = 0;
        if (w > SIZE) w = SIZE;
        return w;
    endfunction

    // One full square: IDLE check, SIZE*SIZE pixel cycles, DONE cycle.
    // With hold set, start stays high and the inputs are scrambled every cycle.
    task automatic draw_sq(input int sx, input int sy, input int c, input bit hold);
        int ex, ey, r, cl, exp_we, writes, exp_writes;
        bit brd;
        @(negedge clk);
        chk("idle_busy", int'(busy), 0);
        chk("idle_done", int'(done), 0);
        chk_quiet("idle");
        start      = 1'b1;
        starting_x = 8'(sx);
        starting_y = 7'(sy);
        colour_in  = 3'(c);
        writes     = 0;
        exp_writes = 0;
        for (int k = 0; k < SIZE * SIZE; k++) begin
            @(negedge clk);
            if (hold) begin
                starting_x = 8'($urandom);
                starting_y = 7'($urandom);
                colour_in  = 3'($urandom);
            end else begin
                start = 1'b0;
            end
            r      = k / SIZE;
            cl     = k % SIZE;
            ex     = sx + cl;
            ey     = sy + r;
            brd    = !BORDER || r == 0 || r == SIZE - 1 || cl == 0 || cl == SIZE - 1;
            exp_we = (ex <= X_MAX && ey <= Y_MAX && brd) ? 1 : 0;
            chk("draw_we",     int'(writeEn), exp_we);
            chk("draw_x",      int'(x),       ex % 256);
            chk("draw_y",      int'(y),       ey % 128);
            chk("draw_colour", int'(colour),  c);
            chk("draw_busy",   int'(busy),    1);
            chk("draw_done",   int'(done),    0);
            writes     += int'(writeEn);
            exp_writes += exp_we;
        end
        @(negedge clk);
        chk("done_pulse", int'(done), 1);
        chk("done_busy",  int'(busy), 1);
        chk_quiet("done");
        if (!BORDER)
            chk("write_count", writes, span(sx, X_MAX) * span(sy, Y_MAX));
        else if (sx + SIZE - 1 <= X_MAX && sy + SIZE - 1 <= Y_MAX)
            chk("outline_count", writes, 4 * SIZE - 4);
        else
            chk("outline_count", writes, exp_writes);
        if (!hold) start = 1'b0;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL timeout: got no finish expected finish");
        $fatal(1, "timeout");
    end

    initial begin
        int sx, sy;
        reset      = 1'b1;
        start      = 1'b0;
        starting_x = '0;
        starting_y = '0;
        colour_in  = '0;
        #1;
        chk("rst_busy", int'(busy), 0);
        chk("rst_done", int'(done), 0);
        chk_quiet("rst");
        repeat (2) @(negedge clk);
        reset = 1'b0;

        draw_sq(10, 112, 3'b100, 1'b0);
        draw_sq(158, 118, 3'b010, 1'b0);
        draw_sq(20, 100, 3'b111, 1'b0);
        draw_sq(30, 112, 3'b000, 1'b0);
        draw_sq(0, 0, 3'b001, 1'b0);
        draw_sq(255, 127, 3'b011, 1'b0);

        // back-to-back with start held high
        draw_sq(50, 60, 3'b101, 1'b1);
        draw_sq(157, 20, 3'b110, 1'b1);
        draw_sq(70, 117, 3'b010, 1'b0);

        // reset on the 6th DRAW cycle
        @(negedge clk);
        start      = 1'b1;
        starting_x = 8'd40;
        starting_y = 7'd50;
        colour_in  = 3'b111;
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            start = 1'b0;
        end
        chk("pre_rst_we", int'(writeEn), 1);
        reset = 1'b1;
        #1;
        chk("async_busy", int'(busy), 0);
        chk("async_done", int'(done), 0);
        chk_quiet("async");
        @(negedge clk);
        reset = 1'b0;
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            chk("post_rst_we",   int'(writeEn), 0);
            chk("post_rst_done", int'(done),    0);
            chk("post_rst_busy", int'(busy),    0);
        end

        for (int i = 0; i < 24; i++) begin
            sx = (i % 2 == 0) ? int'($urandom_range(150, 255)) : int'($urandom_range(0, 255));
            sy = (i % 3 == 0) ? int'($urandom_range(110, 127)) : int'($urandom_range(0, 127));
            draw_sq(sx, sy, int'($urandom_range(0, 7)), ($urandom_range(0, 3) == 0));
        end
        draw_sq(5, 5, 3'b001, 1'b0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/square_drawer.md
SQUARE_DRAWER -- requirements
Module: square_drawer

Interface
REQ-001 SHALL have parameter SIZE, default 4, meaning square edge length in pixels; legal range 2..8.
REQ-002 SHALL have parameter X_MAX, default 159, meaning the last visible column.
REQ-003 SHALL have parameter Y_MAX, default 119, meaning the last visible row.
REQ-004 SHALL use one clock; reset is asynchronous and active-high.
REQ-005 SHALL have port clk, input, 1 bit: the single rising-edge clock.
REQ-006 SHALL have port reset, input, 1 bit: asynchronous active-high reset.
REQ-007 SHALL have port start, input, 1 bit: request to draw one square.
REQ-008 SHALL have port starting_x, input, 8 bits: top-left column of the square.
REQ-009 SHALL have port starting_y, input, 7 bits: top-left row of the square.
REQ-010 SHALL have port colour_in, input, 3 bits: RGB colour to paint (3'b000 erases).
REQ-011 SHALL have port x, output, 8 bits: pixel column to the VGA adapter.
REQ-012 SHALL have port y, output, 7 bits: pixel row to the VGA adapter.
REQ-013 SHALL have port colour, output, 3 bits: pixel colour to the VGA adapter.
REQ-014 SHALL have port writeEn, output, 1 bit: pixel write strobe.
REQ-015 SHALL have port busy, output, 1 bit: high whenever the FSM is not IDLE.
REQ-016 SHALL have port done, output, 1 bit: one-cycle completion pulse.

Function
REQ-017 SHALL implement the states IDLE, DRAW and DONE.
REQ-018 In IDLE with start=1 at a clock edge, SHALL latch starting_x, starting_y and colour_in, clear pixel counter cnt, and go to DRAW.
REQ-019 SHALL ignore start in DRAW and DONE; the latched values SHALL remain unchanged.
REQ-020 In DRAW, SHALL form col = cnt mod SIZE and row = cnt / SIZE; col varies fastest (row-major order).
REQ-021 SHALL drive x = latched_x + col and y = latched_y + row, computed 9/8 bits wide before truncation, and colour = latched colour.
REQ-022 SHALL assert writeEn only in DRAW, and only when the untruncated x <= X_MAX and y <= Y_MAX; out-of-bounds pixels are clipped and never wrapped.
REQ-023 SHALL increment cnt every DRAW cycle; at cnt = SIZE*SIZE-1 the next state SHALL be DONE.
REQ-024 DRAW SHALL last exactly SIZE*SIZE cycles regardless of clipping.
REQ-025 DONE SHALL assert done for exactly one cycle and then return to IDLE.
REQ-026 busy SHALL be high for SIZE*SIZE+1 cycles per accepted start; a start in the first IDLE cycle after DONE SHALL be accepted.
REQ-027 In IDLE and DONE, x, y, colour and writeEn SHALL be 0.

Reset
REQ-028 Reset SHALL force IDLE, cnt=0, latched registers=0, and x=0, y=0, colour=0, writeEn=0, busy=0, done=0 immediately, independent of clk.
REQ-029 Reset asserted mid-DRAW SHALL abort the square; no further writeEn until a new start is accepted after reset deasserts.

Configuration
REQ-030 SHALL support macro SQUARE_BORDER_EN.
REQ-031 When SQUARE_BORDER_EN is defined, writeEn SHALL additionally require row = 0, row = SIZE-1, col = 0 or col = SIZE-1 (outline only); DRAW timing SHALL be unchanged.
REQ-032 When SQUARE_BORDER_EN is undefined, SHALL draw all SIZE*SIZE pixels (filled square).

Verification
REQ-033 SIZE=4, start with (10,112) and colour 3'b100 -> 16 writes, (10,112),(11,112)..(13,115), colour 100; done pulses in the 17th cycle after the start edge; busy is high for 17 cycles.
REQ-034 Start with (158,118) -> 16 DRAW cycles; writeEn only for (158,118),(159,118),(158,119),(159,119).
REQ-035 start held high throughout a draw, with starting_x changed mid-draw -> output pixels still use the originally latched x; the next square starts the cycle after done.
REQ-036 Reset pulsed on the 6th DRAW cycle -> all outputs 0 asynchronously; no writeEn and no done until a new start.
REQ-037 SQUARE_BORDER_EN defined, SIZE=4, at (20,100) -> 12 writes; interior pixels (21..22,101..102) are never written; done is still in cycle 17.
REQ-038 colour_in=3'b000 at (30,112) -> 16 erase writes with colour 000.
